// File: rtl/mips_exec_core.sv
`default_nettype none
// ============================================================================
//  Module   : mips_exec_core
//  Brief    : Single-cycle MIPS decode/execute slice: main control, ALU
//             control, operand-B select with sign extension, 32-bit ALU and
//             a registered copy of the ALU result and zero flag.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_exec_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_read1,
    input  logic [31:0] i_read2,
    output logic        o_reg_dst,
    output logic        o_branch,
    output logic        o_mem_read,
    output logic        o_mem_to_reg,
    output logic        o_mem_write,
    output logic        o_alu_src,
    output logic        o_reg_write,
    output logic        o_jump,
    output logic [1:0]  o_alu_op,
    output logic [3:0]  o_alu_ctrl,
    output logic [4:0]  o_write_addr,
    output logic [31:0] o_imm_ext,
    output logic [31:0] o_alu_result,
    output logic        o_alu_zero,
    output logic [31:0] o_result_q,
    output logic        o_zero_q
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_SLT  = 4'b0111;
    localparam logic [3:0] c_ALU_NOR  = 4'b1100;
    localparam logic [3:0] c_ALU_BAD  = 4'b1111;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [31:0] w_op_b;
    logic [31:0] r_result_q;
    logic        r_zero_q;

    assign w_opcode = i_instr[31:26];
    assign w_funct  = i_instr[5:0];

    // Main control decode from the opcode; unknown opcodes leave everything low
    always_comb begin
        o_reg_dst    = 1'b0;
        o_branch     = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_to_reg = 1'b0;
        o_mem_write  = 1'b0;
        o_alu_src    = 1'b0;
        o_reg_write  = 1'b0;
        o_jump       = 1'b0;
        o_alu_op     = 2'b00;
        case (w_opcode)
            c_OP_RTYPE: begin
                o_reg_dst   = 1'b1;
                o_reg_write = 1'b1;
                o_alu_op    = 2'b10;
            end
            c_OP_LW: begin
                o_alu_src    = 1'b1;
                o_mem_to_reg = 1'b1;
                o_reg_write  = 1'b1;
                o_mem_read   = 1'b1;
            end
            c_OP_SW: begin
                o_alu_src   = 1'b1;
                o_mem_write = 1'b1;
            end
            c_OP_BEQ: begin
                o_branch = 1'b1;
                o_alu_op = 2'b01;
            end
            c_OP_ADDI: begin
                o_alu_src   = 1'b1;
                o_reg_write = 1'b1;
            end
            c_OP_J: begin
                o_jump = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU control: class from main control, refined by funct for R-type
    always_comb begin
        o_alu_ctrl = c_ALU_ADD;
        case (o_alu_op)
            2'b01: o_alu_ctrl = c_ALU_SUB;
            2'b10: begin
                case (w_funct)
                    6'b100000: o_alu_ctrl = c_ALU_ADD;
                    6'b100010: o_alu_ctrl = c_ALU_SUB;
                    6'b100100: o_alu_ctrl = c_ALU_AND;
                    6'b100101: o_alu_ctrl = c_ALU_OR;
                    6'b101010: o_alu_ctrl = c_ALU_SLT;
                    6'b100111: o_alu_ctrl = c_ALU_NOR;
                    default:   o_alu_ctrl = c_ALU_BAD;
                endcase
            end
            default: o_alu_ctrl = c_ALU_ADD;
        endcase
    end

    assign o_write_addr = o_reg_dst ? i_instr[15:11] : i_instr[20:16];
    assign o_imm_ext    = {{16{i_instr[15]}}, i_instr[15:0]};
    assign w_op_b       = o_alu_src ? o_imm_ext : i_read2;

    // 32-bit ALU; unsupported codes yield zero so the zero flag reads 1
    always_comb begin
        o_alu_result = 32'd0;
        case (o_alu_ctrl)
            c_ALU_AND: o_alu_result = i_read1 & w_op_b;
            c_ALU_OR:  o_alu_result = i_read1 | w_op_b;
            c_ALU_ADD: o_alu_result = i_read1 + w_op_b;
            c_ALU_SUB: o_alu_result = i_read1 - w_op_b;
            c_ALU_SLT: o_alu_result = {31'd0, ($signed(i_read1) < $signed(w_op_b))};
            c_ALU_NOR: o_alu_result = ~(i_read1 | w_op_b);
            default:   o_alu_result = 32'd0;
        endcase
    end

    assign o_alu_zero = (o_alu_result == 32'd0);

    // Registered copy of result and zero flag, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_q <= 32'd0;
            r_zero_q   <= 1'b0;
        end else begin
            r_result_q <= o_alu_result;
            r_zero_q   <= o_alu_zero;
        end
    end

    assign o_result_q = r_result_q;
    assign o_zero_q   = r_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_exec_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_exec_core
//  Brief    : Self-checking bench for mips_exec_core; registered outputs are
//             checked through an expected-value queue one cycle after drive.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_exec_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr, read1, read2;
    logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, jump;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctrl;
    logic [4:0]  write_addr;
    logic [31:0] imm_ext, alu_result, result_q;
    logic        alu_zero, zero_q;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [32:0] sb_q[$];   // {result, zero} expected after next edge
    logic [9:0]  ctl;

    assign ctl = {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, jump, alu_op};

    mips_exec_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_instr      (instr),
        .i_read1      (read1),
        .i_read2      (read2),
        .o_reg_dst    (reg_dst),
        .o_branch     (branch),
        .o_mem_read   (mem_read),
        .o_mem_to_reg (mem_to_reg),
        .o_mem_write  (mem_write),
        .o_alu_src    (alu_src),
        .o_reg_write  (reg_write),
        .o_jump       (jump),
        .o_alu_op     (alu_op),
        .o_alu_ctrl   (alu_ctrl),
        .o_write_addr (write_addr),
        .o_imm_ext    (imm_ext),
        .o_alu_result (alu_result),
        .o_alu_zero   (alu_zero),
        .o_result_q   (result_q),
        .o_zero_q     (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: each pushed expectation is compared just after the next edge
    always @(posedge clk) begin
        logic [32:0] exp_v;
        #1;
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            total_cnt++;
            if ({result_q, zero_q} !== exp_v)
                $display("FAIL sb_reg: result_q=%h zero_q=%b expected result_q=%h zero_q=%b",
                         result_q, zero_q, exp_v[32:1], exp_v[0]);
            else
                pass_cnt++;
        end
    end

    // Independent reference ALU for randomised R-type traffic
    function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h27:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] ref_ctrl(input logic [5:0] f);
        case (f)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            6'h27:   return 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        instr = i; read1 = a; read2 = b;
        #1;
    endtask

    task automatic test_reset;
        instr = 32'h012A4020; read1 = 32'd5; read2 = 32'd7; rst_n = 1'b0;
        #2;
        total_cnt++;
        if ({result_q, zero_q} !== 33'd0)
            $display("FAIL reset_initial: result_q=%h zero_q=%b expected 0/0", result_q, zero_q);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({result_q, zero_q} !== 33'd0)
            $display("FAIL reset_hold: result_q=%h zero_q=%b expected 0/0", result_q, zero_q);
        else pass_cnt++;
        total_cnt++;
        if (alu_result !== 32'd12)
            $display("FAIL reset_comb_indep: alu_result=%h expected 0000000c", alu_result);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        apply(32'h012A4020, 32'd5, 32'd7);
        total_cnt++;
        if ({ctl, alu_ctrl, write_addr, alu_result, alu_zero} !== {10'b1000001010, 4'b0010, 5'd8, 32'd12, 1'b0})
            $display("FAIL add: ctl=%b ctrl=%b wa=%0d res=%h z=%b expected 1000001010/0010/8/0000000c/0",
                     ctl, alu_ctrl, write_addr, alu_result, alu_zero);
        else pass_cnt++;
        sb_q.push_back({32'd12, 1'b0});
    endtask

    task automatic test_branch;
        apply(32'h112A0003, 32'h55, 32'h55);
        total_cnt++;
        if ({ctl, alu_ctrl, alu_result, alu_zero, write_addr} !== {10'b0100000001, 4'b0110, 32'd0, 1'b1, 5'd10})
            $display("FAIL beq_equal: ctl=%b ctrl=%b res=%h z=%b wa=%0d expected 0100000001/0110/0/1/10",
                     ctl, alu_ctrl, alu_result, alu_zero, write_addr);
        else pass_cnt++;
        sb_q.push_back({32'd0, 1'b1});
        apply(32'h112A0003, 32'h55, 32'h54);
        total_cnt++;
        if ({alu_result, alu_zero} !== {32'd1, 1'b0})
            $display("FAIL beq_noteq: res=%h z=%b expected 00000001/0", alu_result, alu_zero);
        else pass_cnt++;
        sb_q.push_back({32'd1, 1'b0});
    endtask

    task automatic test_load_store_jump;
        apply(32'h8D280004, 32'h100, 32'hDEAD);
        total_cnt++;
        if ({ctl, write_addr, alu_result} !== {10'b0011011000, 5'd8, 32'h104})
            $display("FAIL lw: ctl=%b wa=%0d res=%h expected 0011011000/8/00000104", ctl, write_addr, alu_result);
        else pass_cnt++;
        sb_q.push_back({32'h104, 1'b0});
        apply(32'hAD280004, 32'h200, 32'hDEAD);
        total_cnt++;
        if ({ctl, alu_ctrl, alu_result} !== {10'b0000110000, 4'b0010, 32'h204})
            $display("FAIL sw: ctl=%b ctrl=%b res=%h expected 0000110000/0010/00000204", ctl, alu_ctrl, alu_result);
        else pass_cnt++;
        sb_q.push_back({32'h204, 1'b0});
        apply(32'h08000010, 32'd3, 32'd4);
        total_cnt++;
        if ({ctl, alu_ctrl, alu_result} !== {10'b0000000100, 4'b0010, 32'd7})
            $display("FAIL j: ctl=%b ctrl=%b res=%h expected 0000000100/0010/00000007", ctl, alu_ctrl, alu_result);
        else pass_cnt++;
        sb_q.push_back({32'd7, 1'b0});
    endtask

    task automatic test_sign_ext;
        apply(32'h2128FFFF, 32'd1, 32'd9);
        total_cnt++;
        if ({ctl, imm_ext, alu_result, alu_zero} !== {10'b0000011000, 32'hFFFFFFFF, 32'd0, 1'b1})
            $display("FAIL addi_neg: ctl=%b imm=%h res=%h z=%b expected 0000011000/ffffffff/0/1",
                     ctl, imm_ext, alu_result, alu_zero);
        else pass_cnt++;
        sb_q.push_back({32'd0, 1'b1});
        apply(32'h21287FFF, 32'd1, 32'd9);
        total_cnt++;
        if ({imm_ext, alu_result} !== {32'h00007FFF, 32'h00008000})
            $display("FAIL addi_pos: imm=%h res=%h expected 00007fff/00008000", imm_ext, alu_result);
        else pass_cnt++;
        sb_q.push_back({32'h8000, 1'b0});
    endtask

    task automatic test_slt;
        apply(32'h012A402A, 32'hFFFFFFFF, 32'd1);
        total_cnt++;
        if ({alu_ctrl, alu_result} !== {4'b0111, 32'd1})
            $display("FAIL slt_neg_lt: ctrl=%b res=%h expected 0111/00000001", alu_ctrl, alu_result);
        else pass_cnt++;
        sb_q.push_back({32'd1, 1'b0});
        apply(32'h012A402A, 32'd1, 32'hFFFFFFFF);
        total_cnt++;
        if ({alu_result, alu_zero} !== {32'd0, 1'b1})
            $display("FAIL slt_swapped: res=%h z=%b expected 0/1", alu_result, alu_zero);
        else pass_cnt++;
        sb_q.push_back({32'd0, 1'b1});
    endtask

    task automatic test_unknown;
        apply(32'hFC000000, 32'd2, 32'd3);
        total_cnt++;
        if ({ctl, alu_ctrl, alu_result} !== {10'd0, 4'b0010, 32'd5})
            $display("FAIL bad_opcode: ctl=%b ctrl=%b res=%h expected 0000000000/0010/00000005",
                     ctl, alu_ctrl, alu_result);
        else pass_cnt++;
        sb_q.push_back({32'd5, 1'b0});
        apply(32'h012A4021, 32'h1234, 32'h5678);
        total_cnt++;
        if ({alu_ctrl, alu_result, alu_zero} !== {4'b1111, 32'd0, 1'b1})
            $display("FAIL bad_funct: ctrl=%b res=%h z=%b expected 1111/0/1", alu_ctrl, alu_result, alu_zero);
        else pass_cnt++;
        sb_q.push_back({32'd0, 1'b1});
        apply(32'h012A4020, 32'h7FFFFFFF, 32'd1);
        total_cnt++;
        if (alu_result !== 32'h80000000)
            $display("FAIL add_wrap: res=%h expected 80000000", alu_result);
        else pass_cnt++;
        sb_q.push_back({32'h80000000, 1'b0});
    endtask

    task automatic test_async_reset;
        apply(32'h012A4020, 32'd5, 32'd7);
        sb_q.push_back({32'd12, 1'b0});
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({result_q, zero_q} !== 33'd0)
            $display("FAIL async_reset: result_q=%h zero_q=%b expected 0/0", result_q, zero_q);
        else pass_cnt++;
        @(posedge clk);
        #2;
        total_cnt++;
        if ({result_q, zero_q} !== 33'd0)
            $display("FAIL async_reset_hold: result_q=%h zero_q=%b expected 0/0", result_q, zero_q);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sb_q.push_back({32'd12, 1'b0});
    endtask

    task automatic test_back_to_back;
        logic [5:0]  fl [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h03};
        logic [5:0]  f;
        logic [31:0] a, b, e;
        for (int k = 0; k < 24; k++) begin
            f = fl[$urandom_range(0, 6)];
            a = $urandom();
            b = (k % 5 == 0) ? a : $urandom();
            e = ref_alu(f, a, b);
            apply({6'd0, 5'd9, 5'd10, 5'd8, 5'd0, f}, a, b);
            total_cnt++;
            if ({alu_ctrl, alu_result, alu_zero} !== {ref_ctrl(f), e, (e == 32'd0)})
                $display("FAIL b2b_%0d: f=%h ctrl=%b res=%h z=%b expected %b/%h/%b",
                         k, f, alu_ctrl, alu_result, alu_zero, ref_ctrl(f), e, (e == 32'd0));
            else pass_cnt++;
            sb_q.push_back({e, (e == 32'd0)});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_load_store_jump();
        test_sign_ext();
        test_slt();
        test_unknown();
        test_async_reset();
        test_back_to_back();
        @(posedge clk);
        #3;
        total_cnt++;
        if (sb_q.size() != 0)
            $display("FAIL sb_drain: %0d entries left expected 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
